// File: rtl/fp_norm_sequencer_pkg.sv
// Shared definitions for the mantissa normalizer: FSM state encoding,
// the chunk width scanned per cycle by the leading-one detector, and the
// helper that sizes the leading-zero-count field for a given mantissa width.
package fp_norm_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int CHUNK = 8;

  // Count field must hold 0..w inclusive (w when the mantissa is zero).
  function automatic int lzc_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/fp_norm_sequencer_if.sv
// Handshake bundle around the normalizer: upstream request (in_*) and
// downstream result (out_*), both valid/ready.
// Ports: master = producer/consumer side (drives in_*, out_ready);
//        slave  = normalizer side (drives in_ready, out_*).
interface fp_norm_sequencer_if
  import fp_norm_sequencer_pkg::*;
#(
  parameter int W  = 24,
  parameter int EW = 8
) ();

  localparam int LW = lzc_width(W);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_mant;
  logic [EW-1:0] in_exp;

  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_mant;
  logic [EW-1:0] out_exp;
  logic [LW-1:0] out_lzc;
  logic          out_zero;
  logic          out_underflow;

  modport master (
    output in_valid, in_mant, in_exp, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_lzc, out_zero, out_underflow
  );

  modport slave (
    input  in_valid, in_mant, in_exp, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_lzc, out_zero, out_underflow
  );

endinterface

// File: rtl/leading_one_detector_8.sv
// Purpose: count leading zeros of one byte (position of the leading one from the MSB).
// Latency: combinational. Backpressure: none.
// Ports: d_i byte under test; n_o leading-zero count 0..7 (7 also for a zero byte).
module leading_one_detector_8 (
  input  logic [7:0] d_i,
  output logic [2:0] n_o
);

  // Walk LSB->MSB so the highest set bit is the last (winning) assignment.
  always_comb begin
    n_o = 3'd7;
    for (int i = 0; i < 8; i++) begin
      if (d_i[i]) n_o = 3'(7 - i);
    end
  end

endmodule

// File: rtl/fp_norm_sequencer.sv
// Purpose: normalize a W-bit mantissa by scanning it a byte per cycle through one
//          shared leading-one detector, then shifting and adjusting the exponent.
// Latency: k+1 cycles accept->out_valid (k = first nonzero byte, 1-based); NCH for zero.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
// Ports: clk, rst (sync, active-high); bus = slave side of fp_norm_sequencer_if.
module fp_norm_sequencer
  import fp_norm_sequencer_pkg::*;
#(
  parameter int W  = 24,
  parameter int EW = 8
) (
  input logic                clk,
  input logic                rst,
  fp_norm_sequencer_if.slave bus
);

  localparam int LW   = lzc_width(W);
  localparam int NCH  = W / CHUNK;
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CMPW = (LW > EW) ? LW : EW;

  state_e        state_q, state_d;
  logic [W-1:0]  mant_q, mant_d;
  logic [EW-1:0] exp_q, exp_d;
  logic [LW-1:0] lzc_q, lzc_d;
  logic [CW-1:0] c_q, c_d;

  logic [W-1:0]  out_mant_q, out_mant_d;
  logic [EW-1:0] out_exp_q, out_exp_d;
  logic [LW-1:0] out_lzc_q, out_lzc_d;
  logic          out_zero_q, out_zero_d;
  logic          out_uf_q, out_uf_d;

  logic [CHUNK-1:0] chunk;
  logic [2:0]       lod_n;
  logic [CMPW-1:0]  lzc_x, exp_x, s_x;
  logic             lzc_lt_exp;

  // Byte c counted from the MSB; constant-index mux keeps the select simple.
  always_comb begin
    chunk = '0;
    for (int i = 0; i < NCH; i++) begin
      if (c_q == CW'(i)) chunk = mant_q[W-1-CHUNK*i -: CHUNK];
    end
  end

  leading_one_detector_8 u_lod (
    .d_i (chunk),
    .n_o (lod_n)
  );

  // Shift amount is the lzc clamped to the exponent so out_exp never wraps.
  assign lzc_x      = CMPW'(lzc_q);
  assign exp_x      = CMPW'(exp_q);
  assign lzc_lt_exp = (lzc_x < exp_x);
  assign s_x        = lzc_lt_exp ? lzc_x : exp_x;

  always_comb begin
    state_d    = state_q;
    mant_d     = mant_q;
    exp_d      = exp_q;
    lzc_d      = lzc_q;
    c_d        = c_q;
    out_mant_d = out_mant_q;
    out_exp_d  = out_exp_q;
    out_lzc_d  = out_lzc_q;
    out_zero_d = out_zero_q;
    out_uf_d   = out_uf_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mant_d  = bus.in_mant;
          exp_d   = bus.in_exp;
          lzc_d   = '0;
          c_d     = '0;
          state_d = SCAN;
        end
      end

      SCAN: begin
        // The detector reports 7 for a zero byte as well as for 0x01, so a
        // zero byte is recognised here and its n is never used.
        if (chunk == '0) begin
          lzc_d = lzc_q + LW'(CHUNK);
          if (c_q == CW'(NCH - 1)) begin
            out_zero_d = 1'b1;
            out_mant_d = '0;
            out_exp_d  = '0;
            out_lzc_d  = LW'(W);
            out_uf_d   = 1'b0;
            state_d    = DONE;
          end else begin
            c_d = c_q + 1'b1;
          end
        end else begin
          lzc_d   = lzc_q + LW'(lod_n);
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        out_mant_d = mant_q << s_x;
        out_exp_d  = exp_q - s_x[EW-1:0];
        out_uf_d   = !lzc_lt_exp;
        out_lzc_d  = lzc_q;
        out_zero_d = 1'b0;
        state_d    = DONE;
      end

      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mant_q     <= '0;
      exp_q      <= '0;
      lzc_q      <= '0;
      c_q        <= '0;
      out_mant_q <= '0;
      out_exp_q  <= '0;
      out_lzc_q  <= '0;
      out_zero_q <= 1'b0;
      out_uf_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mant_q     <= mant_d;
      exp_q      <= exp_d;
      lzc_q      <= lzc_d;
      c_q        <= c_d;
      out_mant_q <= out_mant_d;
      out_exp_q  <= out_exp_d;
      out_lzc_q  <= out_lzc_d;
      out_zero_q <= out_zero_d;
      out_uf_q   <= out_uf_d;
    end
  end

  assign bus.in_ready      = (state_q == IDLE) && !rst;
  assign bus.out_valid     = (state_q == DONE);
  assign bus.out_mant      = out_mant_q;
  assign bus.out_exp       = out_exp_q;
  assign bus.out_lzc       = out_lzc_q;
  assign bus.out_zero      = out_zero_q;
  assign bus.out_underflow = out_uf_q;

endmodule

// File: doc/fp_norm_sequencer.md
Name: fp_norm_sequencer

Overview:
Multi-cycle mantissa normalizer that time-shares one 8-bit leading-one detector, leading_one_detector_8, across a W-bit mantissa. It scans the mantissa one byte per cycle from the MSB to accumulate a leading-zero count. It then left-shifts the mantissa and decrements the exponent, clamping at exponent 0 for subnormal results. It sits after FP add/sub and mul datapaths, ahead of rounding, with valid/ready handshakes on both sides.

Parameters:
W, 24, mantissa width; must be a multiple of 8 and at least 8.
EW, 8, exponent width; exponent is unsigned and biased.
(derived) NCH = W/8, number of chunks; LW = clog2(W+1), width of out_lzc.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input request
in_ready  out  1  input accepted when in_valid && in_ready
in_mant  in  W  unnormalized mantissa
in_exp  in  EW  biased exponent of in_mant
out_valid  out  1  result valid
out_ready  in  1  downstream accepts when out_valid && out_ready
out_mant  out  W  normalized mantissa
out_exp  out  EW  adjusted exponent
out_lzc  out  LW  leading-zero count of in_mant (W when zero)
out_zero  out  1  in_mant was zero
out_underflow  out  1  lzc >= in_exp; result clamped to exponent 0

Behaviour:
- One clock domain, clk. rst is synchronous and active-high.
- Reset state:
  - State goes to IDLE.
  - out_valid, out_mant, out_exp, out_lzc, out_zero and out_underflow are all 0.
  - in_ready is 0 while rst is high.
- States: IDLE, SCAN, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On handshake, register mant and exp, clear lzc, set chunk index c = 0, go to SCAN.
- SCAN: one chunk per cycle; chunk = mant[W-1-8c -: 8] feeds the single LOD instance.
  - Chunk == 0: lzc += 8. If c == NCH-1, go to DONE with out_zero=1, out_mant=0, out_exp=0, out_lzc=W, out_underflow=0. Otherwise c++.
  - Chunk != 0: lzc += LOD n, go to SHIFT.
  - The LOD returns 7 for a zero input, which is ambiguous with input 0x01. Zero chunks are therefore detected by the sequencer with its own compare and never use n.
- SHIFT (one cycle):
  - s = (lzc < exp) ? lzc : exp.
  - out_mant = mant << s, using a barrel shift of width W.
  - out_exp = exp - s.
  - out_underflow = (lzc >= exp).
  - out_lzc = lzc. Go to DONE.
- DONE:
  - out_valid = 1.
  - Outputs are held stable while out_ready = 0.
  - On handshake, out_valid goes to 0 next cycle and state goes to IDLE.
- Latency: let k = 1-based index of the first nonzero chunk.
  - Nonzero input: out_valid goes high k+1 clocks after the accept edge.
  - Zero input: out_valid goes high NCH clocks after the accept edge.
  - Minimum accept-to-accept interval is k+3 cycles.
- Boundary cases:
  - in_exp = 0 gives s = 0: mantissa unshifted, underflow=1 unless the input is zero.
  - lzc == exp gives out_exp = 0 with a fully normalized mantissa; underflow=1.
  - Inputs are ignored outside IDLE.
  - rst in any state aborts the operation, discards the result, and returns to IDLE next cycle with out_valid=0.
  - All arithmetic is unsigned. lzc <= W fits in LW bits. exp - s never goes negative.

Decomposition:
- Shared package holds:
  - the state encoding constants (IDLE=0, SCAN=1, SHIFT=2, DONE=3);
  - CHUNK=8;
  - the LW derivation function.
- Exactly one instance of leading_one_detector_8, which is the shared resource.
- No other sub-module; the shifter and counters are inline.

Test Plan:
- W=24, EW=8; in_mant=0x800000, in_exp=100 -> out_mant=0x800000, out_exp=100, out_lzc=0, flags 0; out_valid 2 cycles after accept.
- in_mant=0x000001, in_exp=100 -> out_lzc=23, out_mant=0x800000, out_exp=77; out_valid 4 cycles after accept (exercises the LOD n=7 path).
- in_mant=0x000000, in_exp=50 -> out_zero=1, out_mant=0, out_exp=0, out_lzc=24, underflow=0; out_valid 3 cycles after accept.
- in_mant=0x001234, in_exp=5 -> out_lzc=11, s=5, out_mant=0x024680, out_exp=0, out_underflow=1.
- Back-pressure: out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored. After the out handshake, in_ready=1 next cycle and the next operand is accepted.
- Reset mid-operation: rst pulsed on the 2nd SCAN cycle of 0x000001 -> state IDLE next cycle, out_valid never asserts, in_ready=1 after rst falls.
